ocra1_iface: RTL and testbench
==============================

Name: ocra1_iface

Overview:
- FPGA-side transmitter for the OCRA1 gradient board: serialises four 24-bit AD5781 words (X, Y, Z, Z2) in parallel on four SDO lines.
- Shares one serial clock and SYNC frame across all four lines; optionally pulses LDAC after the frame.
- Sits between the gradient sample scheduler (valid/ready word source) and the OCRA1 connector pins.
- Its pins connect one-to-one to the board's clk, syncn, ldacn, sdox, sdoy, sdoz and sdoz2 inputs.

Parameters:
- CLK_DIV, 2: system cycles per serial-clock half-period; legal range 1..255.
- WORD_BITS, 24: bits per DAC word, shifted MSB first; fixed at 24 for AD5781.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid  in  1  word set available.
- ready  out  1  high only in IDLE; transfer accepted on the edge where valid && ready.
- data_x, data_y, data_z, data_z2  in  24 each  DAC words, latched on acceptance.
- ldac_en  in  1  latched on acceptance; 1 = pulse ldacn after the frame.
- done  out  1  one-cycle pulse when the frame (incl. LDAC) completes.
- oc1_clk  out  1  serial clock to the board.
- oc1_syncn  out  1  frame select, active low.
- oc1_ldacn  out  1  load DAC, active low.
- oc1_sdox, oc1_sdoy, oc1_sdoz, oc1_sdoz2  out  1 each  serial data lines.

Behaviour:
- All board outputs are registered.
- Reset values: oc1_clk=0, oc1_syncn=1, oc1_ldacn=1, all oc1_sdo*=0, done=0, state=IDLE (so ready=1).
- rst mid-frame aborts immediately and asynchronously to the reset values; there is no partial-frame recovery.
- Timing unit: D = CLK_DIV. One 8-bit divider counter plus a 5-bit bit index.

State machine:
- IDLE: outputs at idle values; on valid && ready, latch all inputs and go to SETUP.
- SETUP (D cycles): from the accept edge, syncn=0, clk=0, every sdo = bit 23 of its word.
- SHIFT (48·D cycles), for bit i = 23 down to 0:
  - High phase (D cycles): clk=1; sdo = bit i, updated on the same edge clk rises.
  - Low phase (D cycles): clk=0; sdo holds.
  - The board samples on the falling edge, mid-bit. Bit 23's data is already stable from SETUP.
- HOLD (D cycles): clk=0, syncn=0, sdo holds bit 0.
- GAP (D cycles): syncn=1, sdo=0.
- GAP exit: if latched ldac_en=1, go to LDAC; else go to IDLE with done=1 for one cycle.
- LDAC (D cycles): ldacn=0. Then ldacn=1, go to IDLE, done=1 for one cycle.

Timing and boundaries:
- Accept-to-ready: 51·D cycles without LDAC, 52·D with LDAC. Exactly 24 clk rising edges per frame; syncn low for 50·D cycles.
- Input changes while not in IDLE are ignored; latched words are immutable during a frame.
- valid held high across done: the next frame is accepted on the first IDLE cycle (the done cycle itself), so back-to-back frames have a GAP+LDAC minimum separation.
- CLK_DIV=1: clk toggles every cycle (sysclk/2); all phases still 1 cycle.
- Never overlap syncn low and ldacn low; never toggle clk while syncn=1.

Test Plan:
- Reset then idle: after rst deassert, ready=1, syncn=1, ldacn=1, clk=0, sdo*=0 and stable for 100 cycles with valid=0.
- Single frame, D=2, ldac_en=0, data_x=24'hA5_5A_F0, data_y=24'h000001, data_z=24'h800000, data_z2=24'hFFFFFF:
  - 24 clk rises; bits sampled on falling edges reproduce each word exactly.
  - syncn low exactly 100 cycles; ldacn never low.
  - done at cycle 102 after accept; ready back at cycle 102.
- Same frame with ldac_en=1: ldacn low for exactly 2 cycles, starting 2 cycles after syncn rises; done at cycle 104.
- Back-to-back, D=1, valid held high with two different word sets: second frame accepted on the done cycle; both decoded correctly; syncn high ≥1 cycle between frames.
- Reset mid-frame (rst asserted at bit 10): all outputs at reset values within the same cycle. Next frame after release is decoded in full with no leftover bits.
- Input mutation: change data_* and ldac_en every cycle during a frame; the transmitted frame equals the accepted values.

Source files
------------

// File: rtl/ocra1_iface.sv
// OCRA1 gradient-board transmitter: shifts four 24-bit AD5781 words out in parallel
// under one shared serial clock and SYNC frame, with an optional LDAC pulse afterwards.
module ocra1_iface #(
    parameter int CLK_DIV   = 2,
    parameter int WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic [WORD_BITS-1:0] data_x,
    input  logic [WORD_BITS-1:0] data_y,
    input  logic [WORD_BITS-1:0] data_z,
    input  logic [WORD_BITS-1:0] data_z2,
    input  logic                 ldac_en,
    output logic                 done,
    output logic                 oc1_clk,
    output logic                 oc1_syncn,
    output logic                 oc1_ldacn,
    output logic                 oc1_sdox,
    output logic                 oc1_sdoy,
    output logic                 oc1_sdoz,
    output logic                 oc1_sdoz2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_MSB  = 5'(WORD_BITS - 1);

    state_t                 r_state;
    logic [7:0]             r_div;
    logic [4:0]             r_bit;
    logic                   r_high;
    logic [WORD_BITS-1:0]   r_x;
    logic [WORD_BITS-1:0]   r_y;
    logic [WORD_BITS-1:0]   r_z;
    logic [WORD_BITS-1:0]   r_z2;
    logic                   r_ldac;
    logic                   r_done;
    logic                   r_clk;
    logic                   r_syncn;
    logic                   r_ldacn;
    logic [3:0]             r_sdo;

    state_t                 w_state;
    logic [7:0]             w_div;
    logic [4:0]             w_bit;
    logic                   w_high;
    logic                   w_done;
    logic                   w_last;
    logic                   w_clk;
    logic                   w_syncn;
    logic                   w_ldacn;
    logic [3:0]             w_sdo;
    logic [WORD_BITS-1:0]   w_wx;
    logic [WORD_BITS-1:0]   w_wy;
    logic [WORD_BITS-1:0]   w_wz;
    logic [WORD_BITS-1:0]   w_wz2;

    assign w_last = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_high  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_z2    <= '0;
            r_ldac  <= 1'b0;
            r_done  <= 1'b0;
            r_clk   <= 1'b0;
            r_syncn <= 1'b1;
            r_ldacn <= 1'b1;
            r_sdo   <= '0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_high  <= w_high;
            r_done  <= w_done;
            r_clk   <= w_clk;
            r_syncn <= w_syncn;
            r_ldacn <= w_ldacn;
            r_sdo   <= w_sdo;
            if (r_state == S_IDLE && valid) begin
                r_x    <= data_x;
                r_y    <= data_y;
                r_z    <= data_z;
                r_z2   <= data_z2;
                r_ldac <= ldac_en;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_high  = r_high;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_state = S_SETUP;
                    w_div   = '0;
                    w_bit   = BIT_MSB;
                    w_high  = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_last) begin
                    w_state = S_SHIFT;
                    w_div   = '0;
                    w_high  = 1'b1;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_div = '0;
                    if (r_high) begin
                        w_high = 1'b0;
                    end else if (r_bit == 5'd0) begin
                        w_state = S_HOLD;
                    end else begin
                        w_bit  = r_bit - 5'd1;
                        w_high = 1'b1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    w_state = S_GAP;
                    w_div   = '0;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    w_div = '0;
                    if (r_ldac) begin
                        w_state = S_LDAC;
                    end else begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_LDAC: begin
                if (w_last) begin
                    w_state = S_IDLE;
                    w_div   = '0;
                    w_done  = 1'b1;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_div   = '0;
            end
        endcase
    end

    // Pins are decoded from the next state so each registered output lands on the
    // same edge as its state change; on the accept edge the words come straight from the inputs.
    always_comb begin
        w_wx    = (r_state == S_IDLE) ? data_x  : r_x;
        w_wy    = (r_state == S_IDLE) ? data_y  : r_y;
        w_wz    = (r_state == S_IDLE) ? data_z  : r_z;
        w_wz2   = (r_state == S_IDLE) ? data_z2 : r_z2;
        w_clk   = 1'b0;
        w_syncn = 1'b1;
        w_ldacn = 1'b1;
        w_sdo   = '0;
        case (w_state)
            S_SETUP, S_SHIFT, S_HOLD: begin
                w_syncn = 1'b0;
                w_clk   = (w_state == S_SHIFT) && w_high;
                w_sdo   = {w_wx[w_bit], w_wy[w_bit], w_wz[w_bit], w_wz2[w_bit]};
            end
            S_LDAC: begin
                w_ldacn = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign ready     = (r_state == S_IDLE);
    assign done      = r_done;
    assign oc1_clk   = r_clk;
    assign oc1_syncn = r_syncn;
    assign oc1_ldacn = r_ldacn;
    assign oc1_sdox  = r_sdo[3];
    assign oc1_sdoy  = r_sdo[2];
    assign oc1_sdoz  = r_sdo[1];
    assign oc1_sdoz2 = r_sdo[0];

endmodule

// File: tb/tb_ocra1_iface.sv
// Scoreboard bench for ocra1_iface: one instance at CLK_DIV=2, one at CLK_DIV=1;
// monitors decode the pins and compare each frame against queued expectations.
module tb_ocra1_iface;

    typedef struct packed {
        int          inst;
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
        logic [23:0] z2;
        logic        l;
    } exp_t;

    localparam logic [8:0] IDLE_PINS = 9'b011000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin [2];
    logic [23:0] data_x = '0;
    logic [23:0] data_y = '0;
    logic [23:0] data_z = '0;
    logic [23:0] data_z2 = '0;
    logic        ldac_en = 1'b0;

    logic ready_v [2];
    logic done_v  [2];
    logic ck_v    [2];
    logic sn_v    [2];
    logic ln_v    [2];
    logic sx_v    [2];
    logic sy_v    [2];
    logic sz_v    [2];
    logic sz2_v   [2];

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   busy_v [2];
    int   last_acc [2];
    int   last_done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ocra1_iface #(.CLK_DIV(2), .WORD_BITS(24)) dut2 (
        .clk(clk), .rst(rst), .valid(vin[0]), .ready(ready_v[0]),
        .data_x(data_x), .data_y(data_y), .data_z(data_z), .data_z2(data_z2),
        .ldac_en(ldac_en), .done(done_v[0]), .oc1_clk(ck_v[0]), .oc1_syncn(sn_v[0]),
        .oc1_ldacn(ln_v[0]), .oc1_sdox(sx_v[0]), .oc1_sdoy(sy_v[0]),
        .oc1_sdoz(sz_v[0]), .oc1_sdoz2(sz2_v[0])
    );

    ocra1_iface #(.CLK_DIV(1), .WORD_BITS(24)) dut1 (
        .clk(clk), .rst(rst), .valid(vin[1]), .ready(ready_v[1]),
        .data_x(data_x), .data_y(data_y), .data_z(data_z), .data_z2(data_z2),
        .ldac_en(ldac_en), .done(done_v[1]), .oc1_clk(ck_v[1]), .oc1_syncn(sn_v[1]),
        .oc1_ldacn(ln_v[1]), .oc1_sdox(sx_v[1]), .oc1_sdoy(sy_v[1]),
        .oc1_sdoz(sz_v[1]), .oc1_sdoz2(sz2_v[1])
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int D = (g == 0) ? 2 : 1;
        int          low_cnt = 0, rises = 0, ld_cnt = 0, rise_cyc = 0, acc_cyc = 0;
        logic        prev_ck = 1'b0, prev_sn = 1'b1, prev_ln = 1'b1;
        logic        cur_l = 1'b0, seen_rise = 1'b0;
        logic [23:0] bx = '0, by = '0, bz = '0, bz2 = '0;
        logic [8:0]  pins;
        exp_t        e;

        always @(negedge clk) begin
            pins = {ck_v[g], sn_v[g], ln_v[g], sx_v[g], sy_v[g], sz_v[g], sz2_v[g],
                    done_v[g], ready_v[g]};
            if (rst) begin
                chk($sformatf("rst_pins%0d", g), pins, IDLE_PINS);
                busy_v[g] = 1'b0;
                low_cnt = 0; rises = 0; ld_cnt = 0; seen_rise = 1'b0;
            end else begin
                if (busy_v[g] && done_v[g]) begin
                    chk($sformatf("done_latency%0d", g), cyc - acc_cyc, (cur_l ? 52 : 51) * D);
                    chk($sformatf("ldac_len%0d", g), ld_cnt, cur_l ? D : 0);
                    chk($sformatf("done_ready%0d", g), ready_v[g], 1);
                    last_done[g] = cyc;
                    busy_v[g] = 1'b0;
                    ld_cnt = 0;
                end else if (!busy_v[g]) begin
                    chk($sformatf("idle_pins%0d", g), pins, IDLE_PINS);
                end else begin
                    chk($sformatf("busy_ready%0d", g), ready_v[g], 0);
                end

                if (!sn_v[g]) begin
                    low_cnt++;
                    chk($sformatf("no_overlap%0d", g), ln_v[g], 1);
                    if (prev_sn && seen_rise)
                        chk($sformatf("sync_gap%0d", g), (cyc - rise_cyc) >= 1, 1);
                    if (!prev_ck && ck_v[g]) rises++;
                    if (prev_ck && !ck_v[g]) begin
                        bx  = {bx[22:0], sx_v[g]};
                        by  = {by[22:0], sy_v[g]};
                        bz  = {bz[22:0], sz_v[g]};
                        bz2 = {bz2[22:0], sz2_v[g]};
                    end
                end else begin
                    chk($sformatf("clk_quiet%0d", g), ck_v[g], 0);
                    if (!prev_sn) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame%0d: unexpected frame, got data x=%h, expected none", g, bx);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("frame%0d_inst", g), g, e.inst);
                            chk($sformatf("frame%0d_x", g), bx, e.x);
                            chk($sformatf("frame%0d_y", g), by, e.y);
                            chk($sformatf("frame%0d_z", g), bz, e.z);
                            chk($sformatf("frame%0d_z2", g), bz2, e.z2);
                            cur_l = e.l;
                        end
                        chk($sformatf("frame%0d_rises", g), rises, 24);
                        chk($sformatf("frame%0d_sync_low", g), low_cnt, 50 * D);
                        rise_cyc = cyc;
                        seen_rise = 1'b1;
                        low_cnt = 0;
                        rises = 0;
                    end
                end

                if (!ln_v[g]) begin
                    ld_cnt++;
                    if (prev_ln) chk($sformatf("ldac_start%0d", g), cyc - rise_cyc, D);
                end

                if (vin[g] && ready_v[g]) begin
                    busy_v[g] = 1'b1;
                    acc_cyc = cyc + 1;
                    last_acc[g] = cyc + 1;
                end
            end
            prev_ck = ck_v[g];
            prev_sn = sn_v[g];
            prev_ln = ln_v[g];
        end
    end

    task automatic send(input int inst, input logic [23:0] x, input logic [23:0] y,
                        input logic [23:0] z, input logic [23:0] z2, input logic l,
                        input bit push);
        int   n;
        logic acc;
        exp_t en;
        en = '{inst: inst, x: x, y: y, z: z, z2: z2, l: l};
        if (push) exp_q.push_back(en);
        data_x = x; data_y = y; data_z = z; data_z2 = z2; ldac_en = l;
        vin[inst] = 1'b1;
        n = 0;
        forever begin
            acc = ready_v[inst];
            @(posedge clk);
            #1;
            n++;
            if (acc) break;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout%0d: got no ready, expected ready within 2000 cycles", inst);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (busy_v[inst] && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("idle_timeout%0d", inst), busy_v[inst], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vin[0] = 1'b0;
        vin[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        send(0, 24'hA55AF0, 24'h000001, 24'h800000, 24'hFFFFFF, 1'b0, 1'b1);
        vin[0] = 1'b0;
        wait_idle(0);
        repeat (5) @(posedge clk);
        #1;

        send(0, 24'hA55AF0, 24'h000001, 24'h800000, 24'hFFFFFF, 1'b1, 1'b1);
        vin[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(posedge clk);
        #1;

        send(0, 24'h3C96E1, 24'h7F00FE, 24'h123456, 24'hC0FFEE, 1'b0, 1'b1);
        vin[0] = 1'b0;
        for (int n = 0; n < 3000 && busy_v[0]; n++) begin
            data_x  = 24'($urandom);
            data_y  = 24'($urandom);
            data_z  = 24'($urandom);
            data_z2 = 24'($urandom);
            ldac_en = 1'($urandom);
            @(posedge clk);
            #1;
        end
        wait_idle(0);
        repeat (3) @(posedge clk);
        #1;

        // Abort at the start of bit 10's high phase (edge 54 after accept at D=2).
        send(0, 24'hDEADBE, 24'hEF0123, 24'h456789, 24'hABCDEF, 1'b1, 1'b0);
        vin[0] = 1'b0;
        repeat (54) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(0, 24'h5A5A5A, 24'h0F1E2D, 24'hFEDCBA, 24'h000000, 1'b1, 1'b1);
        vin[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(posedge clk);
        #1;

        send(1, 24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678, 1'b0, 1'b1);
        send(1, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0, 24'h555555, 1'b1, 1'b1);
        vin[1] = 1'b0;
        chk("b2b_accept_on_done", last_acc[1], last_done[1] + 1);
        wait_idle(1);
        repeat (5) @(posedge clk);
        #1;

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
